uart_tx_dds: RTL and testbench

//  UART transmitter, TX-side counterpart of the RX path. An internal phase accumulator paces the bits.
//  It serialises one byte per valid/ready handshake as start, DATA_BITS (LSB first), optional parity, STOP_BITS.

---
 rtl/uart_tx_dds_if.sv | 34 +++
 rtl/uart_tx_dds.sv | 157 +++++++++++++++
 tb/tb_uart_tx_dds.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_dds_if.sv
// uart_tx_dds_if
//  Byte-stream handshake and serial-line bundle for the phase-accumulator UART
//  transmitter.
//  Signals:
//    phase_increment  baud control word (sampled when a frame is accepted)
//    tx_data          byte to send (sampled when a frame is accepted)
//    tx_valid         source has a byte
//    tx_ready         transmitter can accept a frame
//    tx               serial line, idle high
//    busy             frame in progress
//  Modports:
//    master  byte source: drives data/valid/increment, observes ready/line/busy
//    slave   transmitter: the opposite directions
interface uart_tx_dds_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_BITS   = 8
);
  logic [PHASE_WIDTH-1:0] phase_increment;
  logic [DATA_BITS-1:0]   tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx;
  logic                   busy;

  modport master (
    output phase_increment, tx_data, tx_valid,
    input  tx_ready, tx, busy
  );

  modport slave (
    input  phase_increment, tx_data, tx_valid,
    output tx_ready, tx, busy
  );
endinterface

// File: rtl/uart_tx_dds.sv
// uart_tx_dds
//  UART transmitter paced by a phase accumulator instead of a clock divider.
//  Each accepted byte goes out as: start bit, DATA_BITS data bits (LSB first),
//  an optional parity bit, then STOP_BITS stop bits.
//  Baud = f_clk * phase_increment / 2^PHASE_WIDTH; the carry out of the
//  accumulator is the bit-advance tick.
//  Ports:
//    clk  rising-edge clock
//    rst  synchronous, active-high reset
//    bus  uart_tx_dds_if.slave: phase_increment, tx_data, tx_valid in;
//         tx_ready, tx, busy out (all outputs registered)
module uart_tx_dds #(
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_dds_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] inc_lat;
  logic [DATA_BITS-1:0]   data_lat;
  logic [DATA_BITS-1:0]   shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [1:0]             stop_cnt;
  logic                   tx_r;
  logic                   busy_r;
  logic                   ready_r;

  logic [PHASE_WIDTH:0]   acc_sum;
  logic                   baud_tick;
  logic                   accept;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // The accumulator is never cleared between bits, so the fractional
  // remainder carries into the next bit and the average bit length is exact.
  assign acc_sum   = {1'b0, acc} + {1'b0, inc_lat};
  assign baud_tick = acc_sum[PHASE_WIDTH];
  assign accept    = (state == IDLE) && ready_r && bus.tx_valid;

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.tx_ready = ready_r;

  // Frame payload: captured at acceptance, shifted one bit per data tick.
  // shreg[1] is the bit that goes on the line at the next data tick.
  always_ff @(posedge clk) begin
    if (accept) begin
      inc_lat  <= bus.phase_increment;
      data_lat <= bus.tx_data;
      shreg    <= bus.tx_data;
    end else if (state == DATA && baud_tick) begin
      shreg <= shreg >> 1;
    end
  end

  // Control FSM with registered line, busy and ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      acc      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      if (state != IDLE) begin
        acc <= acc_sum[PHASE_WIDTH-1:0];
      end
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (accept) begin
            acc     <= '0;
            tx_r    <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= START;
          end else begin
            ready_r <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            tx_r    <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_r  <= parity_bit(data_lat);
              end else begin
                state <= STOP;
                tx_r  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_r    <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state    <= STOP;
            tx_r     <= 1'b1;
            stop_cnt <= '0;
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state   <= IDLE;
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_dds.sv
// tb_uart_tx_dds
//  Bench for uart_tx_dds with PHASE_WIDTH=8. Four instances share the input
//  drives: 8N1, 8E1, 8O1 and 8N2; sel chooses which one gets tx_valid and is
//  observed. Expected line levels per clock are queued when a frame is driven
//  and popped while the DUT is busy.
module tb_uart_tx_dds;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tb_inc;
  logic [7:0] tb_data;
  logic       tb_valid;
  int         sel;

  logic       obs_tx, obs_ready, obs_busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       exp_q[$];
  logic       mid_valid;
  logic [7:0] mid_data;
  logic       cap38;

  always #5 clk = ~clk;

  uart_tx_dds_if #(.PHASE_WIDTH(8), .DATA_BITS(8)) bus0 ();
  uart_tx_dds_if #(.PHASE_WIDTH(8), .DATA_BITS(8)) bus1 ();
  uart_tx_dds_if #(.PHASE_WIDTH(8), .DATA_BITS(8)) bus2 ();
  uart_tx_dds_if #(.PHASE_WIDTH(8), .DATA_BITS(8)) bus3 ();

  assign bus0.phase_increment = tb_inc;
  assign bus1.phase_increment = tb_inc;
  assign bus2.phase_increment = tb_inc;
  assign bus3.phase_increment = tb_inc;
  assign bus0.tx_data = tb_data;
  assign bus1.tx_data = tb_data;
  assign bus2.tx_data = tb_data;
  assign bus3.tx_data = tb_data;
  assign bus0.tx_valid = tb_valid && (sel == 0);
  assign bus1.tx_valid = tb_valid && (sel == 1);
  assign bus2.tx_valid = tb_valid && (sel == 2);
  assign bus3.tx_valid = tb_valid && (sel == 3);

  uart_tx_dds #(.PHASE_WIDTH(8), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_dds #(.PHASE_WIDTH(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx_dds #(.PHASE_WIDTH(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst), .bus(bus2));
  uart_tx_dds #(.PHASE_WIDTH(8), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_8n2 (.clk(clk), .rst(rst), .bus(bus3));

  always_comb begin
    obs_tx    = bus0.tx;
    obs_ready = bus0.tx_ready;
    obs_busy  = bus0.busy;
    case (sel)
      1: begin obs_tx = bus1.tx; obs_ready = bus1.tx_ready; obs_busy = bus1.busy; end
      2: begin obs_tx = bus2.tx; obs_ready = bus2.tx_ready; obs_busy = bus2.busy; end
      3: begin obs_tx = bus3.tx; obs_ready = bus3.tx_ready; obs_busy = bus3.busy; end
      default: ;
    endcase
  end

  // Reference frame: bit list from the frame format, each bit held until the
  // 8-bit accumulator (starting at 0 at acceptance) carries.
  function automatic void push_frame(input logic [7:0] d, input logic [7:0] inc);
    logic bits[$];
    bit   pen, podd;
    int   stops, acc, s;
    pen   = (sel == 1) || (sel == 2);
    podd  = (sel == 2);
    stops = (sel == 3) ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    acc = 0;
    foreach (bits[b]) begin
      do begin
        exp_q.push_back(bits[b]);
        s   = acc + int'(inc);
        acc = s % 256;
      end while (s < 256);
    end
  endfunction

  // Present a frame and return 1 time unit after the acceptance edge.
  task automatic accept(input logic [7:0] d, input logic [7:0] inc, input bit hold, input bit do_push);
    int n;
    tb_data  = d;
    tb_inc   = inc;
    tb_valid = 1'b1;
    mid_data = d;
    mid_valid = hold;
    if (do_push) push_frame(d, inc);
    n = 0;
    while (obs_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", obs_ready, n);
    end
    @(posedge clk);
    #1;
    if (!hold) tb_valid = 1'b0;
  endtask

  // Compare the line each cycle while busy against the queued reference.
  task automatic check_frame(input string name, input int exp_len);
    int   i;
    logic e;
    i = 0;
    @(negedge clk);
    while (obs_busy === 1'b1 && i < 2000) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s overrun: still busy at cycle %0d, required idle", name, i);
      end else begin
        e = exp_q.pop_front();
        if (obs_tx !== e) begin
          n_fail++;
          $display("FAIL %s tx cycle %0d: got %b, required %b", name, i, obs_tx, e);
        end
      end
      if (i == 38) cap38 = obs_tx;
      if (i == 10) begin
        tb_data  = mid_data;
        tb_valid = mid_valid;
      end
      i++;
      @(negedge clk);
    end
    n_tests++;
    if (i !== exp_len) begin
      n_fail++;
      $display("FAIL %s length: got %0d clk, required %0d", name, i, exp_len);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s short: %0d expected cycles left, required 0", name, exp_q.size());
    end
    exp_q.delete();
    n_tests++;
    if (obs_ready !== 1'b1 || obs_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_state: ready=%b tx=%b, required ready=1 tx=1", name, obs_ready, obs_tx);
    end
  endtask

  task automatic test_reset();
    sel      = 0;
    rst      = 1'b1;
    tb_valid = 1'b1;
    tb_data  = 8'h00;
    tb_inc   = 8'd64;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b busy=%b ready=%b, required 1 0 0", obs_tx, obs_busy, obs_ready);
    end
    tb_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 0", obs_ready, obs_busy);
    end
  endtask

  task automatic test_8n1();
    sel = 0;
    accept(8'hA5, 8'd64, 1'b0, 1'b1);
    check_frame("8n1_a5", 40);
  endtask

  task automatic test_parity();
    sel = 1;
    accept(8'h07, 8'd64, 1'b0, 1'b1);
    check_frame("8e1_07", 44);
    n_tests++;
    if (cap38 !== 1'b1) begin
      n_fail++;
      $display("FAIL even_parity_bit: got %b, required 1", cap38);
    end
    sel = 2;
    accept(8'h07, 8'd64, 1'b0, 1'b1);
    check_frame("8o1_07", 44);
    n_tests++;
    if (cap38 !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_parity_bit: got %b, required 0", cap38);
    end
  endtask

  task automatic test_stop2();
    sel = 3;
    accept(8'hA5, 8'd64, 1'b0, 1'b1);
    check_frame("8n2_a5", 44);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    accept(8'h55, 8'd64, 1'b1, 1'b1);
    mid_data = 8'h0F;
    check_frame("b2b_first", 40);
    // Now at the single idle-high cycle; the next edge accepts 0x0F.
    push_frame(8'h0F, 8'd64);
    mid_data  = 8'h0F;
    mid_valid = 1'b0;
    check_frame("b2b_second", 40);
  endtask

  task automatic test_frac_inc();
    sel = 0;
    accept(8'hC3, 8'd96, 1'b0, 1'b1);
    check_frame("inc96_c3", 27);
  endtask

  task automatic test_mid_reset();
    sel = 0;
    accept(8'h00, 8'd64, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    n_tests++;
    if (obs_tx !== 1'b0 || obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: tx=%b busy=%b, required 0 1", obs_tx, obs_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: tx=%b busy=%b ready=%b, required 1 0 0", obs_tx, obs_busy, obs_ready);
    end
    @(negedge clk);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: ready=%b tx=%b, required 1 1", obs_ready, obs_tx);
    end
    accept(8'h3C, 8'd64, 1'b0, 1'b1);
    check_frame("after_rst_3c", 40);
  endtask

  task automatic test_zero_inc();
    int bad;
    sel = 0;
    accept(8'h81, 8'd0, 1'b0, 1'b0);
    bad = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bad < 0 && (obs_tx !== 1'b0 || obs_busy !== 1'b1)) bad = i;
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL zero_inc_stall: left start bit at cycle %0d, required tx=0 busy=1 for 1000", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_inc_recover: ready=%b busy=%b tx=%b, required 1 0 1", obs_ready, obs_busy, obs_tx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tb_valid  = 1'b0;
    tb_data   = 8'h00;
    tb_inc    = 8'd0;
    sel       = 0;
    mid_valid = 1'b0;
    mid_data  = 8'h00;
    cap38     = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_frac_inc();
    test_mid_reset();
    test_zero_inc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
